// File: rtl/ides8_word_align_if.sv
// ides8_word_align_if: signal bundle between an IDES8 deserializer / word consumer and the
// ides8_word_align block.
//   q      [7:0]  deserialized word, q[i] = Qi
//   start         one-cycle pulse, (re)starts alignment
//   train         high while the transmitter sends the training word
//   calib         bitslip pulse back to IDES8 CALIB
//   locked        alignment achieved
//   fail          sticky, all eight slip positions tried without lock
//   slips  [2:0]  CALIB pulses issued since start, modulo 8
//   dout   [7:0]  registered copy of q
//   dvalid        equals locked, aligned with dout
// Modports: master = deserializer/consumer side, slave = ides8_word_align.
interface ides8_word_align_if;
    logic [7:0] q;
    logic       start;
    logic       train;
    logic       calib;
    logic       locked;
    logic       fail;
    logic [2:0] slips;
    logic [7:0] dout;
    logic       dvalid;

    modport master (
        output q, start, train,
        input  calib, locked, fail, slips, dout, dvalid
    );

    modport slave (
        input  q, start, train,
        output calib, locked, fail, slips, dout, dvalid
    );
endinterface

// File: rtl/ides8_word_align.sv
// ides8_word_align: word aligner for an IDES8 1:8 deserializer, running in its PCLK domain.
// Registers q, compares it with the training word PATTERN and pulses calib (bitslip) until
// MATCHES consecutive words match, then reports lock and forwards words with dvalid.
// Ports:
//   pclk   parallel clock (IDES8 PCLK)
//   reset  asynchronous, active-high
//   bus    ides8_word_align_if.slave (q/start/train in; calib/locked/fail/slips/dout/dvalid out)
// Optional feature: define ALIGN_MONITOR_EN to keep checking the link while locked; MISS_LIMIT
// consecutive mismatches during training drop lock and restart the search.
module ides8_word_align #(
    parameter logic [7:0]  PATTERN    = 8'hF0,
    parameter int unsigned MATCHES    = 4,
    parameter int unsigned SETTLE     = 3
`ifdef ALIGN_MONITOR_EN
    ,
    parameter int unsigned MISS_LIMIT = 2
`endif
) (
    input logic               pclk,
    input logic               reset,
    ides8_word_align_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StSlip,
        StWait,
        StLocked,
        StFail
    } state_e;

    localparam logic [3:0] MatchCnt   = 4'(MATCHES);
    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);
`ifdef ALIGN_MONITOR_EN
    localparam logic [3:0] MissCnt    = 4'(MISS_LIMIT);
`endif

    state_e     state;
    logic [7:0] qr;
    logic [3:0] mcnt;
    logic [3:0] wcnt;
    logic [3:0] attempts;
    logic [2:0] slips;
    logic       calib;
    logic       locked;
    logic       fail;
`ifdef ALIGN_MONITOR_EN
    logic [3:0] miss;
`endif

    logic qr_match;
    assign qr_match = (qr == PATTERN);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            qr       <= 8'h00;
            mcnt     <= 4'd0;
            wcnt     <= 4'd0;
            attempts <= 4'd0;
            slips    <= 3'd0;
            calib    <= 1'b0;
            locked   <= 1'b0;
            fail     <= 1'b0;
`ifdef ALIGN_MONITOR_EN
            miss     <= 4'd0;
`endif
        end else begin
            qr    <= bus.q;
            // calib is only ever raised on entry to StSlip, so it can never exceed one cycle
            calib <= 1'b0;
            if (bus.start) begin
                // start overrides everything, including a final match in the same cycle
                state    <= StCheck;
                mcnt     <= 4'd0;
                wcnt     <= 4'd0;
                attempts <= 4'd0;
                slips    <= 3'd0;
                locked   <= 1'b0;
                fail     <= 1'b0;
`ifdef ALIGN_MONITOR_EN
                miss     <= 4'd0;
`endif
            end else begin
                unique case (state)
                    StIdle: ;
                    StCheck: begin
                        // with train low the word is meaningless: hold mcnt, never slip
                        if (bus.train) begin
                            if (qr_match) begin
                                if (mcnt + 4'd1 == MatchCnt) begin
                                    state  <= StLocked;
                                    locked <= 1'b1;
`ifdef ALIGN_MONITOR_EN
                                    miss   <= 4'd0;
`endif
                                end
                                mcnt <= mcnt + 4'd1;
                            end else begin
                                mcnt <= 4'd0;
                                if (attempts == 4'd8) begin
                                    state <= StFail;
                                    fail  <= 1'b1;
                                end else begin
                                    state    <= StSlip;
                                    calib    <= 1'b1;
                                    slips    <= slips + 3'd1;
                                    attempts <= attempts + 4'd1;
                                end
                            end
                        end
                    end
                    StSlip: begin
                        state <= StWait;
                        wcnt  <= 4'd0;
                    end
                    StWait: begin
                        // give the IDES8 SETTLE cycles to re-frame before judging words again
                        if (wcnt == SettleLast) begin
                            state <= StCheck;
                            mcnt  <= 4'd0;
                        end else begin
                            wcnt <= wcnt + 4'd1;
                        end
                    end
`ifdef ALIGN_MONITOR_EN
                    StLocked: begin
                        if (bus.train) begin
                            if (qr_match) begin
                                miss <= 4'd0;
                            end else if (miss + 4'd1 == MissCnt) begin
                                // same clearing as a start pulse
                                state    <= StCheck;
                                locked   <= 1'b0;
                                mcnt     <= 4'd0;
                                wcnt     <= 4'd0;
                                attempts <= 4'd0;
                                slips    <= 3'd0;
                                fail     <= 1'b0;
                                miss     <= 4'd0;
                            end else begin
                                miss <= miss + 4'd1;
                            end
                        end
                    end
`else
                    StLocked: ;
`endif
                    StFail: ;
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign bus.calib  = calib;
    assign bus.locked = locked;
    assign bus.dvalid = locked;
    assign bus.fail   = fail;
    assign bus.slips  = slips;
    assign bus.dout   = qr;

endmodule

// File: tb/tb_ides8_word_align.sv
// tb_ides8_word_align: directed bench for ides8_word_align with a behavioural IDES8 model
// (q = PATTERN rotated by offset+phase, each sampled calib cycle advances phase by one).
module tb_ides8_word_align;
    logic pclk  = 1'b0;
    logic reset = 1'b1;

    ides8_word_align_if bus ();

    ides8_word_align dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    logic       use_model = 1'b0;
    logic [2:0] offset    = 3'd0;
    logic [7:0] q_fixed   = 8'hF0;
    logic [2:0] phase;
    logic [2:0] sel;

    int n_pulse;
    int run;
    int max_w;
    int gap;
    int min_gap;

    function automatic logic [7:0] rotl(input logic [7:0] x, input logic [2:0] k);
        logic [15:0] t;
        t = {x, x} << k;
        return t[15:8];
    endfunction

    assign sel   = offset + phase;
    assign bus.q = use_model ? rotl(8'hF0, sel) : q_fixed;

    // IDES8 phase model plus calib pulse-width / spacing monitor
    always @(posedge pclk or posedge reset) begin
        if (reset) begin
            phase   <= 3'd0;
            n_pulse <= 0;
            run     <= 0;
            max_w   <= 0;
            gap     <= 0;
            min_gap <= 99;
        end else if (bus.calib) begin
            phase <= phase + 3'd1;
            run   <= run + 1;
            if (run + 1 > max_w) max_w <= run + 1;
            if (run == 0) begin
                n_pulse <= n_pulse + 1;
                if (n_pulse != 0 && gap < min_gap) min_gap <= gap;
            end
            gap <= 0;
        end else begin
            run <= 0;
            if (gap < 1000) gap <= gap + 1;
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.train = 1'b0;
        #12;
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_locked(input int limit);
        for (int i = 0; i < limit && !bus.locked; i++) tick();
    endtask

    task automatic wait_fail(input int limit);
        for (int i = 0; i < limit && !bus.fail; i++) tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.train = 1'b0;

        // ---- reset state
        do_reset();
        chk("rst_calib",  8'(bus.calib),  8'd0);
        chk("rst_locked", 8'(bus.locked), 8'd0);
        chk("rst_fail",   8'(bus.fail),   8'd0);
        chk("rst_slips",  8'(bus.slips),  8'd0);
        chk("rst_dvalid", 8'(bus.dvalid), 8'd0);
        tick();
        chk("idle_dout", bus.dout, 8'hF0);
        chk("idle_locked", 8'(bus.locked), 8'd0);

        // ---- already aligned: lock on the 4th checked word
        bus.train = 1'b1;
        pulse_start();
        tick(); tick(); tick();
        chk("al_not_yet", 8'(bus.locked), 8'd0);
        tick();
        chk("al_locked", 8'(bus.locked), 8'd1);
        chk("al_dvalid", 8'(bus.dvalid), 8'd1);
        chk("al_slips",  8'(bus.slips),  8'd0);
        chk("al_pulses", 8'(n_pulse),    8'd0);
        chk("al_dout",   bus.dout,       8'hF0);

        // ---- lock held after corrupted words (monitor absent) / monitor behaviour
        q_fixed = 8'h0F;
        tick();
        q_fixed = 8'hF0;
        tick(); tick(); tick(); tick();
        chk("one_bad_locked", 8'(bus.locked), 8'd1);
        q_fixed = 8'h0F;
        tick(); tick();
        q_fixed = 8'hF0;
        tick();
`ifdef ALIGN_MONITOR_EN
        chk("two_bad_drop", 8'(bus.locked), 8'd0);
        chk("two_bad_dvalid", 8'(bus.dvalid), 8'd0);
        wait_locked(40);
        chk("two_bad_relock", 8'(bus.locked), 8'd1);
`else
        tick(); tick();
        chk("two_bad_held", 8'(bus.locked), 8'd1);
`endif

        // ---- start collides with the final match: start wins
        do_reset();
        bus.train = 1'b1;
        pulse_start();
        tick(); tick(); tick();
        pulse_start();
        chk("coll_locked", 8'(bus.locked), 8'd0);
        tick(); tick(); tick();
        chk("coll_not_yet", 8'(bus.locked), 8'd0);
        tick();
        chk("coll_locked_after", 8'(bus.locked), 8'd1);

        // ---- misalignment by 3: five slips
        use_model = 1'b1;
        offset    = 3'd3;
        do_reset();
        bus.train = 1'b1;
        tick();
        pulse_start();
        wait_locked(300);
        chk("mis_locked", 8'(bus.locked), 8'd1);
        chk("mis_pulses", 8'(n_pulse),    8'd5);
        chk("mis_width",  8'(max_w),      8'd1);
        chk("mis_gap_ge4", 8'(min_gap >= 4), 8'd1);
        chk("mis_slips",  8'(bus.slips),  8'd5);
        chk("mis_dout",   bus.dout,       8'hF0);

        // ---- unalignable input: eight slips then fail
        use_model = 1'b0;
        q_fixed   = 8'hAA;
        do_reset();
        bus.train = 1'b1;
        pulse_start();
        wait_fail(400);
        chk("un_fail",   8'(bus.fail),   8'd1);
        chk("un_locked", 8'(bus.locked), 8'd0);
        chk("un_pulses", 8'(n_pulse),    8'd8);
        chk("un_slips",  8'(bus.slips),  8'd0);
        chk("un_width",  8'(max_w),      8'd1);
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("un_no_more", 8'(n_pulse), 8'd8);
        pulse_start();
        chk("un_restart_clear", 8'(bus.fail), 8'd0);

        // ---- train gap: mcnt held while train is low
        q_fixed = 8'hF0;
        do_reset();
        bus.train = 1'b1;
        pulse_start();
        tick(); tick();
        bus.train = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("gap_hold_unlocked", 8'(bus.locked), 8'd0);
        bus.train = 1'b1;
        tick();
        chk("gap_mcnt3", 8'(bus.locked), 8'd0);
        tick();
        chk("gap_mcnt4_lock", 8'(bus.locked), 8'd1);

        // ---- train gap while misaligned: no slip until train returns
        use_model = 1'b1;
        offset    = 3'd6;
        do_reset();
        bus.train = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) tick();
        chk("gap_no_calib", 8'(n_pulse), 8'd0);
        bus.train = 1'b1;
        wait_locked(200);
        chk("gap_locked", 8'(bus.locked), 8'd1);
        chk("gap_slips",  8'(bus.slips),  8'd2);

        // ---- start in the cycle of the 2nd calib
        offset = 3'd3;
        do_reset();
        bus.train = 1'b1;
        pulse_start();
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 200 && seen < 2; i++) begin
                tick();
                if (bus.calib) seen++;
            end
            chk("rs_seen2", 8'(seen), 8'd2);
        end
        pulse_start();
        chk("rs_calib_width", 8'(bus.calib), 8'd0);
        chk("rs_slips0",      8'(bus.slips), 8'd0);
        wait_locked(300);
        chk("rs_locked",   8'(bus.locked), 8'd1);
        chk("rs_slips3",   8'(bus.slips),  8'd3);
        chk("rs_maxwidth", 8'(max_w),      8'd1);

        // ---- asynchronous reset mid-WAIT
        do_reset();
        bus.train = 1'b1;
        pulse_start();
        for (int i = 0; i < 50 && !bus.calib; i++) tick();
        tick();
        chk("ar_pre_slips", 8'(bus.slips), 8'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_slips",  8'(bus.slips),  8'd0);
        chk("ar_dout",   bus.dout,       8'h00);
        chk("ar_calib",  8'(bus.calib),  8'd0);
        chk("ar_locked", 8'(bus.locked), 8'd0);
        chk("ar_fail",   8'(bus.fail),   8'd0);
        #10;
        reset = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ides8_word_align.md
Name: ides8_word_align

Overview:
- Sits directly downstream of an IDES8 1:8 input deserializer and runs in its PCLK domain.
- Registers the eight parallel bits Q0..Q7 and compares them against a known training word.
- Pulses CALIB (bitslip) back to the deserializer until the word boundary matches, then reports lock.
- Forwards aligned words downstream with a valid flag.

Parameters:
- PATTERN, 8'hF0: training word, bit i = Qi. Its 8 rotations must all be distinct.
- MATCHES, 4: consecutive matching words required to declare lock (1..15).
- SETTLE, 3: PCLK cycles ignored after each CALIB pulse while the IDES8 re-frames (1..15).
- MISS_LIMIT, 2: consecutive mismatches in monitor mode that drop lock. Used only with ALIGN_MONITOR_EN.

Ports:
- pclk  in  1  parallel clock, same as IDES8 PCLK.
- reset  in  1  asynchronous, active-high.
- q  in  8  deserialized word, q[i] = Qi.
- start  in  1  one-cycle pulse; (re)starts alignment from any state.
- train  in  1  high while the transmitter sends PATTERN.
- calib  out  1  bitslip pulse to IDES8 CALIB, exactly one pclk wide.
- locked  out  1  alignment achieved.
- fail  out  1  sticky; 8 slips were tried without lock.
- slips  out  3  number of CALIB pulses issued since start, modulo 8.
- dout  out  8  registered copy of q.
- dvalid  out  1  equals locked, aligned with dout.

Behaviour:
- Clocking: single clock pclk; reset is asynchronous and active-high.
- Reset values: calib, locked, fail, dvalid all 0; slips 0; dout 8'h00; state IDLE; all counters 0.
- Input path: q is registered once into qr, so dout = qr. Matching is evaluated on qr. Latency from q to dout is 1 cycle.
- IDLE: all outputs held. start moves to CHECK, clearing slips, fail, the match counter and the slip-attempt counter.
- CHECK:
  - qr==PATTERN with train=1: increment mcnt. When mcnt reaches MATCHES, go to LOCKED.
  - train=0: mcnt held, no slip is issued. The block waits for training.
  - qr!=PATTERN with train=1: mcnt cleared.
    - If attempts==8, go to FAIL.
    - Otherwise go to SLIP.
- SLIP: calib=1 for exactly this one cycle; slips+1 (wraps 7->0); attempts+1. Next state is WAIT.
- WAIT: hold SETTLE cycles with calib=0, then return to CHECK with mcnt=0.
- LOCKED: locked=1 and dvalid=1 from the first cycle of the state. No further calib pulses.
- FAIL: fail=1, locked=0. Stays in FAIL until start or reset.
- start in any state, including mid-SLIP or mid-WAIT: the next state is CHECK and all counters clear. If calib was high that cycle it still completes its single cycle; it is never extended.
- Simultaneous start and a final match: start wins, and locked stays 0.
- Counter widths: mcnt and the WAIT counter are 4 bits; attempts is 4 bits and saturates at 8.
- Two calib pulses are always separated by at least SETTLE+1 cycles.

Optional Feature:
- Macro: ALIGN_MONITOR_EN.
- When defined, LOCKED also monitors the link. While train=1, each qr!=PATTERN increments miss; a match clears it.
  - When miss reaches MISS_LIMIT: locked and dvalid drop in the following cycle, and the block re-enters CHECK with counters cleared exactly as on start.
  - With train=0, miss is held.
- When undefined: LOCKED is left only by start or reset, and the miss logic is absent.

Test Plan:
- Already aligned: reset, start, train=1, q constant 8'hF0 -> no calib pulse; locked=1 on the MATCHES-th (4th) checked word; slips=0.
- Misalignment by 3: behavioural IDES8 model rotating 8'hF0 by 3 per phase, with each calib advancing the phase by one -> exactly 5 calib pulses each 1 cycle wide, gaps of >=4 cycles, slips=5, locked=1, dout=8'hF0.
- Unalignable: q=8'hAA constant with train=1 -> 8 calib pulses, then fail=1, locked=0, slips=0 (wrapped); a further start clears fail.
- Train gaps: alignment sequence with train dropped for 10 cycles mid-CHECK -> no calib issued during the gap; lock is still reached with the correct slips value.
- Restart and reset: start asserted in the cycle of the 2nd calib -> calib width stays 1, slips=0, search restarts. Async reset pulsed mid-WAIT -> all outputs zero immediately, without waiting for a clock edge.
- ALIGN_MONITOR_EN: when locked with train=1, inject 2 corrupted words -> locked falls, a new search starts and relocks. A single corrupted word -> locked stays 1.
